// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// State encoding, legal oversampling ratios, parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  localparam logic [31:0] PRE_8  = 32'd8;
  localparam logic [31:0] PRE_16 = 32'd16;
  localparam logic [31:0] PRE_32 = 32'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic prescale_ok(
    input logic [31:0] p
  );
    return (p == PRE_8) ||
           (p == PRE_16) ||
           (p == PRE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling tick counter and bit counter for the UART receiver.
// Raises bit_end on the last tick of every bit.
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5,
  parameter int BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_p,
  output logic [EDGE_W-1:0]     o_edge_count,
  output logic [BIT_W-1:0]      o_bit_cnt,
  output logic                  o_bit_end
);

  logic [EDGE_W-1:0] r_edge;
  logic [BIT_W-1:0]  r_bit;
  logic [EDGE_W-1:0] w_last_tick;
  logic              w_last;

  assign w_last_tick = EDGE_W'(i_p - PRESCALE_W'(1));
  assign w_last      = (r_edge == w_last_tick);
  assign o_bit_end   = i_en && w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else begin
      if (!i_en || w_last)
        r_edge <= '0;
      else
        r_edge <= r_edge + EDGE_W'(1);
      if (i_clr)
        r_bit <= '0;
      else if (o_bit_end)
        r_bit <= r_bit + BIT_W'(1);
    end
  end

  assign o_edge_count = r_edge;
  assign o_bit_cnt    = r_bit;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, LSB-first deserializer,
// parity/stop checks and one-cycle result pulses.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_sample_en,
  output logic [EDGE_W-1:0]     edge_count,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

  rx_state_e             r_state;
  logic [PRESCALE_W-1:0] r_p;
  logic                  r_pen;
  logic                  r_ptyp;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_err;
  logic                  r_sample_en;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;

  logic [BIT_W-1:0]      w_bit_cnt;
  logic                  w_bit_end;
  logic                  w_last_data;
  logic                  w_clr;

  assign w_clr       = (r_state != DATA);
  assign w_last_data = (w_bit_cnt == BIT_W'(DATA_WIDTH - 1));

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .EDGE_W     (EDGE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_en         (r_sample_en),
    .i_clr        (w_clr),
    .i_p          (r_p),
    .o_edge_count (edge_count),
    .o_bit_cnt    (w_bit_cnt),
    .o_bit_end    (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_pen       <= 1'b0;
      r_ptyp      <= 1'b0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_par_err   <= 1'b0;
      r_sample_en <= 1'b0;
      r_dv        <= 1'b0;
      r_pe        <= 1'b0;
      r_se        <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!RX_IN && prescale_ok(32'(Prescale))) begin
            r_state     <= START;
            r_sample_en <= 1'b1;
            r_p         <= Prescale;
            r_pen       <= PAR_EN;
            r_ptyp      <= PAR_TYP;
            r_par_err   <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            if (sampled_bit) begin
              r_state     <= IDLE;
              r_sample_en <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_bit_end) begin
            // Right shift: after DATA_WIDTH bits the first bit sits in bit 0.
            r_shreg <= {sampled_bit, r_shreg[DATA_WIDTH-1:1]};
            if (w_last_data)
              r_state <= r_pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_par_err <= (sampled_bit != (^r_shreg ^ r_ptyp));
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state     <= DONE;
            r_sample_en <= 1'b0;
            r_pe        <= r_par_err;
            r_se        <= ~sampled_bit;
            r_dv        <= ~r_par_err & sampled_bit;
            if (~r_par_err & sampled_bit)
              r_data <= r_shreg;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_sample_en <= 1'b0;
        end
      endcase
    end
  end

  assign data_sample_en = r_sample_en;
  assign P_DATA         = r_data;
  assign data_valid     = r_dv;
  assign parity_error   = r_pe;
  assign stop_error     = r_se;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a simple 3-tap majority sampler.
// Inputs change on the falling edge; outputs are checked there too.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit = 1'b1;
  logic       data_sample_en;
  logic [4:0] edge_count;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int n_vec = 0;
  int n_err = 0;
  int cur_p = 8;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  logic [7:0] dq[$];
  logic s0, s1, s2;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .RX_IN          (RX_IN),
    .Prescale       (Prescale),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .sampled_bit    (sampled_bit),
    .data_sample_en (data_sample_en),
    .edge_count     (edge_count),
    .P_DATA         (P_DATA),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .stop_error     (stop_error)
  );

  // Sampler: three samples around mid-bit, vote ready well before bit-end.
  always @(posedge clk) begin
    if (data_sample_en) begin
      if (int'(edge_count) == cur_p/2 - 2) s0 <= RX_IN;
      if (int'(edge_count) == cur_p/2 - 1) s1 <= RX_IN;
      if (int'(edge_count) == cur_p/2)     s2 <= RX_IN;
      if (int'(edge_count) == cur_p/2 + 1)
        sampled_bit <= (s0 & s1) | (s0 & s2) | (s1 & s2);
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      dq.push_back(P_DATA);
    end
    if (parity_error) pe_cnt = pe_cnt + 1;
    if (stop_error)   se_cnt = se_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    RX_IN = v;
    repeat (cur_p) @(negedge clk);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int p, input logic pen, input logic pt);
    cur_p    = p;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = pt;
  endtask

  task automatic send(input logic [7:0] d, input logic pen,
                      input logic pbit, input logic sbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(sbit);
  endtask

  int base;

  initial begin
    rst = 1'b0;
    RX_IN = 1'b1;
    set_cfg(8, 1'b0, PAR_EVEN);
    repeat (3) @(negedge clk);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_edge", 32'(edge_count), 0);
    chk("rst_sen", 32'(data_sample_en), 0);
    chk("rst_pdata", 32'(P_DATA), 0);
    rst = 1'b1;
    idle(4);

    // 8N1 0xA5, pulse lands on the 81st posedge counted from start entry
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("t1_early", 32'(data_valid), 0);
    @(negedge clk);
    chk("t1_dv", 32'(data_valid), 1);
    chk("t1_data", 32'(P_DATA), 32'hA5);
    chk("t1_pe", 32'(parity_error), 0);
    chk("t1_se", 32'(stop_error), 0);
    @(negedge clk);
    chk("t1_dv_one", 32'(data_valid), 0);
    idle(4);

    // P=16 even parity, 0x3C good then bad parity bit
    set_cfg(16, 1'b1, PAR_EVEN);
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_dv", 32'(data_valid), 1);
    chk("t2_data", 32'(P_DATA), 32'h3C);
    idle(4);
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2b_pe", 32'(parity_error), 1);
    chk("t2b_dv", 32'(data_valid), 0);
    chk("t2b_se", 32'(stop_error), 0);
    chk("t2b_data", 32'(P_DATA), 32'h3C);
    idle(4);

    // P=32 odd parity, correct parity but stop bit 0
    set_cfg(32, 1'b1, PAR_ODD);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_se", 32'(stop_error), 1);
    chk("t3_pe", 32'(parity_error), 0);
    chk("t3_dv", 32'(data_valid), 0);
    idle(6);

    // P=16 start glitch, 4 low cycles
    set_cfg(16, 1'b0, PAR_EVEN);
    base = dv_cnt + pe_cnt + se_cnt;
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_sen_on", 32'(data_sample_en), 1);
    repeat (2) @(negedge clk);
    idle(20);
    chk("t4_sen_off", 32'(data_sample_en), 0);
    chk("t4_edge", 32'(edge_count), 0);
    chk("t4_nopulse", 32'(dv_cnt + pe_cnt + se_cnt), 32'(base));

    // P=8 back-to-back frames with no idle gap
    set_cfg(8, 1'b0, PAR_EVEN);
    base = dv_cnt;
    dq.delete();
    send(8'h55, 1'b0, 1'b0, 1'b1);
    send(8'hF0, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("t5_cnt", 32'(dv_cnt - base), 2);
    chk("t5_d0", (dq.size() > 0) ? 32'(dq[0]) : 32'hDEAD, 32'h55);
    chk("t5_d1", (dq.size() > 1) ? 32'(dq[1]) : 32'hDEAD, 32'hF0);

    // reset in the middle of 0x81 data bits
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_sen", 32'(data_sample_en), 0);
    chk("t6_edge", 32'(edge_count), 0);
    chk("t6_pdata", 32'(P_DATA), 0);
    chk("t6_dv", 32'(data_valid | parity_error | stop_error), 0);
    @(negedge clk);
    RX_IN = 1'b1;
    rst = 1'b1;
    idle(4);
    send(8'h81, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_dv_after", 32'(data_valid), 1);
    chk("t6_data_after", 32'(P_DATA), 32'h81);
    idle(4);

    // illegal prescale: nothing happens
    set_cfg(10, 1'b0, PAR_EVEN);
    base = dv_cnt + pe_cnt + se_cnt;
    RX_IN = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_sen", 32'(data_sample_en), 0);
    repeat (25) @(negedge clk);
    chk("t7_edge", 32'(edge_count), 0);
    idle(4);
    chk("t7_nopulse", 32'(dv_cnt + pe_cnt + se_cnt), 32'(base));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-level controller for the UART receiver. It detects the start bit and drives the oversampling sampler through data_sample_en and edge_count. It consumes the sampler's majority-voted sampled_bit and deserializes data LSB-first. It checks parity and stop bit and publishes the received byte with a one-cycle valid pulse. It sits between the RX pin synchronizer and the receive buffer/register file.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_W, 6, width of the Prescale input
EDGE_W, 5, width of edge_count (covers 0..31)

Ports:
clk  in  1  system clock (oversampling clock)
rst  in  1  asynchronous, active-low reset
RX_IN  in  1  synchronized serial line, idle high
Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
sampled_bit  in  1  majority-voted bit from the sampler
data_sample_en  out  1  sampler enable
edge_count  out  EDGE_W  oversampling tick index within the current bit, 0..P-1
P_DATA  out  DATA_WIDTH  received byte; held until the next frame completes
data_valid  out  1  one-cycle pulse: good frame
parity_error  out  1  one-cycle pulse: parity mismatch
stop_error  out  1  one-cycle pulse: stop bit sampled 0

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; all outputs 0, including P_DATA.
- Latch Prescale, PAR_EN and PAR_TYP on the IDLE->START transition as P, pen and ptyp. Mid-frame input changes are ignored.
- IDLE:
  - data_sample_en=0, edge_count=0.
  - Go to START when RX_IN=0 and Prescale is in {8, 16, 32}.
  - An illegal Prescale keeps the block in IDLE, with no outputs.
- edge_count increments every cycle while not in IDLE and wraps at P-1 to 0.
- A bit ends on the cycle where edge_count==P-1 ("bit-end"). At bit-end, sampled_bit is final for that bit (the sampler's vote completes by edge P/2+3 <= P-1). It is captured on that cycle.
- data_sample_en=1 in START, DATA, PARITY and STOP.
- START: at bit-end, sampled_bit=1 means a glitch: go to IDLE with no output pulse. Otherwise go to DATA with bit_cnt=0.
- DATA:
  - At bit-end, shift sampled_bit into the shift register, LSB first: shreg[bit_cnt] <= sampled_bit.
  - Increment bit_cnt. After bit DATA_WIDTH-1, go to PARITY if pen, else STOP.
- PARITY: at bit-end, par_err_r <= sampled_bit != (^shreg XOR ptyp). Go to STOP.
- STOP: at bit-end, stop_err_r <= ~sampled_bit, then go to DONE.
- DONE (one cycle):
  - edge_count=0, data_sample_en=0.
  - If neither error is set: P_DATA <= shreg and data_valid=1 for exactly this cycle.
  - Otherwise assert parity_error and/or stop_error for this cycle; data_valid=0 and P_DATA is unchanged.
  - Next state is IDLE. If RX_IN=0 in DONE, the start is detected the following cycle (back-to-back frames are supported, with a one-cycle slip absorbed by the mid-bit sampling).
- par_err_r and stop_err_r are cleared on IDLE->START.
- Outputs data_valid, parity_error and stop_error are registered. edge_count and data_sample_en are registered state/counter values.
- Latency: data_valid is asserted 1 cycle after the stop bit's bit-end, i.e. (1+DATA_WIDTH+pen+1)*P+1 cycles after the first cycle in START.
- Reset asserted mid-frame aborts the frame immediately with no pulses. After release, the block waits in IDLE for RX_IN=0.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP, DONE
  - legal prescale constants 8, 16, 32
  - parity type constants PAR_EVEN=0, PAR_ODD=1
- Sub-module uart_rx_edge_bit_counter:
  - inputs: enable, P
  - outputs: edge_count, bit_cnt, bit_end strobe
- The FSM, shift register and checks stay in uart_rx_ctrl. The testbench instantiates this block together with the existing sampler.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 (8N1) -> data_valid pulses once, P_DATA=0xA5, both error flags stay 0, pulse at cycle 10*8+1 after START entry.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> P_DATA=0x3C, data_valid=1. Repeat with parity bit 1 -> parity_error pulse, data_valid=0, P_DATA still 0x3C.
- P=32, PAR_EN=1, PAR_TYP=1, send 0x01 with stop bit forced 0 -> stop_error pulse, data_valid=0.
- P=16, RX_IN low for 4 cycles then high -> START glitch rejected, returns to IDLE, no pulses, edge_count returns to 0.
- P=8, two back-to-back frames 0x55 then 0xF0 with zero idle between -> two data_valid pulses, P_DATA 0x55 then 0xF0.
- Assert rst mid-DATA of a 0x81 frame -> all outputs 0 immediately; a subsequent clean frame 0x81 is received correctly. Prescale=10 -> no activity at all.
